// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter that time-shares one registered 4-bit output between four requesters.
// Tenure is bounded to MAX_HOLD cycles while others wait; switch-over between grantees has no bubble.
module rr_mux4_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] R,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] C,
    input  logic [3:0] D,
    output logic [3:0] Y,
    output logic [1:0] S,
    output logic [3:0] G,
    output logic       V
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_y;
    logic [1:0]       r_s;
    logic [3:0]       r_g;
    logic             r_v;

    state_t           w_state;
    logic [1:0]       w_ptr;
    logic [CNT_W-1:0] w_cnt;
    logic [3:0]       w_y;
    logic [1:0]       w_s;
    logic [3:0]       w_g;
    logic             w_v;
    logic [3:0]       w_others;
    logic             w_release;
    logic [3:0]       w_pick_req;
    logic [1:0]       w_pick_ptr;
    logic [2:0]       w_pick;

    // Returns {found, index}; scanning offsets high-to-low lets the nearest offset win.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] data_sel(input logic [1:0] idx, input logic [3:0] a,
                                            input logic [3:0] b, input logic [3:0] c,
                                            input logic [3:0] d);
        logic [3:0] res;
        case (idx)
            2'd0:    res = a;
            2'd1:    res = b;
            2'd2:    res = c;
            2'd3:    res = d;
            default: res = 4'h0;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Next-state, pick and output-register selection.
    always_comb begin
        w_state    = r_state;
        w_ptr      = r_ptr;
        w_cnt      = r_cnt;
        w_y        = r_y;
        w_s        = r_s;
        w_g        = r_g;
        w_v        = r_v;
        w_others   = R & ~onehot(r_s);
        w_release  = ~R[r_s] | ((r_cnt == HOLD_LAST) & (|w_others));
        if (r_state == ST_GRANT) begin
            w_pick_req = w_others;
            w_pick_ptr = r_s + 2'd1;
        end else begin
            w_pick_req = R;
            w_pick_ptr = r_ptr;
        end
        w_pick = rr_pick(w_pick_req, w_pick_ptr);

        case (r_state)
            ST_IDLE: begin
                if (w_pick[2]) begin
                    w_state = ST_GRANT;
                    w_g     = onehot(w_pick[1:0]);
                    w_s     = w_pick[1:0];
                    w_v     = 1'b1;
                    w_y     = data_sel(w_pick[1:0], A, B, C, D);
                    w_cnt   = {CNT_W{1'b0}};
                end else begin
                    w_g = 4'b0000;
                    w_v = 1'b0;
                    w_y = 4'h0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_ptr = r_s + 2'd1;
                    w_cnt = {CNT_W{1'b0}};
                    if (w_pick[2]) begin
                        w_g = onehot(w_pick[1:0]);
                        w_s = w_pick[1:0];
                        w_v = 1'b1;
                        w_y = data_sel(w_pick[1:0], A, B, C, D);
                    end else begin
                        w_state = ST_IDLE;
                        w_g     = 4'b0000;
                        w_v     = 1'b0;
                        w_y     = 4'h0;
                    end
                end else begin
                    w_y = data_sel(r_s, A, B, C, D);
                    // Sole requester at the limit keeps the grant and restarts its tenure.
                    if (r_cnt == HOLD_LAST) begin
                        w_cnt = {CNT_W{1'b0}};
                    end else begin
                        w_cnt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_ptr   = 2'd0;
                w_cnt   = {CNT_W{1'b0}};
                w_y     = 4'h0;
                w_s     = 2'd0;
                w_g     = 4'b0000;
                w_v     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_cnt   <= {CNT_W{1'b0}};
            r_y     <= 4'h0;
            r_s     <= 2'd0;
            r_g     <= 4'b0000;
            r_v     <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_cnt   <= w_cnt;
            r_y     <= w_y;
            r_s     <= w_s;
            r_g     <= w_g;
            r_v     <= w_v;
        end
    end

    assign Y = r_y;
    assign S = r_s;
    assign G = r_g;
    assign V = r_v;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench for rr_mux4_arbiter: directed vector table, hand sequences, random vs model.
module tb_rr_mux4_arbiter;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] R, A, B, C, D;
    logic [3:0] Y, G;
    logic [1:0] S;
    logic       V;

    int n_checks = 0;
    int n_fail   = 0;

    rr_mux4_arbiter #(.MAX_HOLD(MH), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .R(R), .A(A), .B(B), .C(C), .D(D),
        .Y(Y), .S(S), .G(G), .V(V)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  r;
        logic [15:0] dat;   // {D,C,B,A}
        logic [3:0]  ey;
        logic [1:0]  es;
        logic [3:0]  eg;
        logic        ev;
    } vec_t;

    vec_t vq[$];

    // Behavioural model: owner index (-1 = none), pointer, edges into current tenure.
    int         m_owner;
    int         m_ptr;
    int         m_run;
    logic [3:0] m_y;
    logic [1:0] m_s;

    function automatic logic [3:0] dat_of(input logic [15:0] dat, input int ch);
        return 4'((dat >> (4 * ch)) & 16'h000F);
    endfunction

    task automatic model_step(input logic rst, input logic [3:0] r, input logic [15:0] dat);
        logic [3:0] cand;
        bit         need_pick;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_run = 0; m_y = 4'h0; m_s = 2'd0;
        end else begin
            need_pick = 1'b0;
            cand      = r;
            if (m_owner < 0) begin
                need_pick = 1'b1;
            end else begin
                cand = r & ~(4'b0001 << m_owner);
                if (!r[m_owner] || (m_run == MH - 1 && cand != 4'b0000)) begin
                    m_ptr     = (m_owner + 1) % 4;
                    m_owner   = -1;
                    need_pick = 1'b1;
                end else begin
                    m_run = (m_run + 1) % MH;
                    m_y   = dat_of(dat, m_owner);
                end
            end
            if (need_pick) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_owner < 0 && cand[(m_ptr + i) % 4]) begin
                        m_owner = (m_ptr + i) % 4;
                    end
                end
                if (m_owner >= 0) begin
                    m_run = 0; m_s = 2'(m_owner); m_y = dat_of(dat, m_owner);
                end else begin
                    m_y = 4'h0;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] r, input logic [15:0] dat);
        reset = rst; R = r;
        A = dat[3:0]; B = dat[7:4]; C = dat[11:8]; D = dat[15:12];
    endtask

    task automatic step_check(input string tag, input logic [3:0] ey, input logic [1:0] es,
                              input logic [3:0] eg, input logic ev);
        @(posedge clk);
        #1;
        check({tag, ".Y"}, {4'h0, Y}, {4'h0, ey});
        check({tag, ".S"}, {6'h0, S}, {6'h0, es});
        check({tag, ".G"}, {4'h0, G}, {4'h0, eg});
        check({tag, ".V"}, {7'h0, V}, {7'h0, ev});
    endtask

    function automatic vec_t mk(input logic rst, input logic [3:0] r, input logic [15:0] dat,
                                input logic [3:0] ey, input logic [1:0] es,
                                input logic [3:0] eg, input logic ev);
        vec_t v;
        v.rst = rst; v.r = r; v.dat = dat; v.ey = ey; v.es = es; v.eg = eg; v.ev = ev;
        return v;
    endfunction

    logic [3:0]  rr;
    logic [15:0] rd;
    logic        rrst;

    initial begin
        drive(1'b0, 4'h0, 16'h0);
        // Reset with full request load, then first grant goes to ch0.
        vq.push_back(mk(1'b1, 4'b1111, 16'hFFFF, 4'h0, 2'd0, 4'b0000, 1'b0));
        vq.push_back(mk(1'b1, 4'b1111, 16'hFFFF, 4'h0, 2'd0, 4'b0000, 1'b0));
        vq.push_back(mk(1'b0, 4'b1111, 16'hFFFF, 4'hF, 2'd0, 4'b0001, 1'b1));
        // ch0 drops after two granted cycles, ch1 follows, then idle.
        vq.push_back(mk(1'b1, 4'b0000, 16'h0065, 4'h0, 2'd0, 4'b0000, 1'b0));
        vq.push_back(mk(1'b0, 4'b0011, 16'h0065, 4'h5, 2'd0, 4'b0001, 1'b1));
        vq.push_back(mk(1'b0, 4'b0011, 16'h0065, 4'h5, 2'd0, 4'b0001, 1'b1));
        vq.push_back(mk(1'b0, 4'b0010, 16'h0065, 4'h6, 2'd1, 4'b0010, 1'b1));
        vq.push_back(mk(1'b0, 4'b0000, 16'h0065, 4'h0, 2'd1, 4'b0000, 1'b0));
        // Fairness: ch3 holds MAX_HOLD, then ch0, then ch1 before ch3 again.
        vq.push_back(mk(1'b0, 4'b1000, 16'h9321, 4'h9, 2'd3, 4'b1000, 1'b1));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1'b0, 4'b1011, 16'h9321, 4'h9, 2'd3, 4'b1000, 1'b1));
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(1'b0, 4'b1011, 16'h9321, 4'h1, 2'd0, 4'b0001, 1'b1));
        vq.push_back(mk(1'b0, 4'b1011, 16'h9321, 4'h2, 2'd1, 4'b0010, 1'b1));
        // Reset mid-grant on ch2, then R=0110 picks ch1 from pointer 0.
        vq.push_back(mk(1'b1, 4'b0000, 16'h0760, 4'h0, 2'd0, 4'b0000, 1'b0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1'b0, 4'b0100, 16'h0760, 4'h7, 2'd2, 4'b0100, 1'b1));
        vq.push_back(mk(1'b1, 4'b0100, 16'h0760, 4'h0, 2'd0, 4'b0000, 1'b0));
        vq.push_back(mk(1'b0, 4'b0110, 16'h0760, 4'h6, 2'd1, 4'b0010, 1'b1));

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].r, vq[i].dat);
            step_check($sformatf("vec%0d", i), vq[i].ey, vq[i].es, vq[i].eg, vq[i].ev);
        end

        // Sole requester never loses the grant at the hold limit.
        drive(1'b1, 4'b0000, 16'h0A00);
        step_check("solo_rst", 4'h0, 2'd0, 4'b0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 4'b0100, 16'h0A00);
            step_check($sformatf("solo%0d", i), 4'hA, 2'd2, 4'b0100, 1'b1);
        end

        // Full load rotates in blocks of MAX_HOLD with no gap.
        drive(1'b1, 4'b0000, 16'h4321);
        step_check("rot_rst", 4'h0, 2'd0, 4'b0000, 1'b0);
        for (int n = 0; n < 20; n++) begin
            int ch;
            ch = (n / MH) % 4;
            drive(1'b0, 4'b1111, 16'h4321);
            step_check($sformatf("rot%0d", n), 4'(ch + 1), 2'(ch), 4'(1 << ch), 1'b1);
        end

        // Random traffic against the reference model.
        drive(1'b1, 4'b0000, 16'h0000);
        model_step(1'b1, 4'b0000, 16'h0000);
        @(posedge clk);
        #1;
        for (int n = 0; n < 3000; n++) begin
            rrst = ($urandom_range(0, 199) == 0);
            rr   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rr = 4'b1111;
            rd   = 16'($urandom);
            drive(rrst, rr, rd);
            model_step(rrst, rr, rd);
            step_check($sformatf("rnd%0d", n), m_y, m_s,
                       (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000, m_owner >= 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
